// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : IF stage with IF/ID pipeline register. Owns the PC and a
//             word-addressed instruction memory loaded by the Debug Unit.
//             Picks the next PC from sequential / jump / jr-jalr / branch
//             sources and handles stall, flush and sticky halt.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int INST_SIZE      = 32,
  parameter int PC_SIZE        = 32,
  parameter int IMEM_ADDR_SIZE = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_pipeline_enable,
  input  logic                      i_imem_write_en,
  input  logic [IMEM_ADDR_SIZE-1:0] i_imem_write_addr,
  input  logic [INST_SIZE-1:0]      i_imem_write_data,
  input  logic                      i_stall,
  input  logic                      i_branch_taken,
  input  logic [PC_SIZE-1:0]        i_branch_addr,
  input  logic                      i_jr_jalr,
  input  logic [PC_SIZE-1:0]        i_jr_addr,
  input  logic                      i_jump,
  input  logic [PC_SIZE-1:0]        i_jump_addr,
  input  logic                      i_halt,
  output logic [INST_SIZE-1:0]      o_inst,
  output logic [PC_SIZE-1:0]        o_pc,
  output logic [PC_SIZE-1:0]        o_pc_current,
  output logic                      o_halted
);

  localparam int                   c_IMEM_DEPTH = 2 ** IMEM_ADDR_SIZE;
  localparam logic [PC_SIZE-1:0]   c_PC_ONE     = {{(PC_SIZE-1){1'b0}}, 1'b1};
  localparam logic [INST_SIZE-1:0] c_NOP        = '0;

  // Action selected for the current edge, in decreasing priority order.
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_HALT   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_JUMP   = 3'd4,
    SEL_SEQ    = 3'd5
  } sel_e;

  logic [INST_SIZE-1:0] r_mem [c_IMEM_DEPTH];
  logic [PC_SIZE-1:0]   r_pc;
  logic [INST_SIZE-1:0] r_inst;
  logic [PC_SIZE-1:0]   r_pc_plus1;
  logic                 r_halted;

  sel_e                 w_sel;
  logic [INST_SIZE-1:0] w_fetch_word;
  logic [PC_SIZE-1:0]   w_pc_inc;
  logic [PC_SIZE-1:0]   w_pc_next;
  logic [INST_SIZE-1:0] w_inst_next;
  logic [PC_SIZE-1:0]   w_pc_plus1_next;
  logic                 w_halted_next;

  // Upper PC bits are ignored, so the fetch address wraps modulo the depth.
  // Read is combinational; a write on the same edge lands after the capture,
  // so IF/ID sees the old word.
  assign w_fetch_word = r_mem[r_pc[IMEM_ADDR_SIZE-1:0]];
  assign w_pc_inc     = r_pc + c_PC_ONE;

  // Debug Unit write port: independent of pipeline enable and halt state.
  always_ff @(posedge i_clock) begin
    if (i_imem_write_en) begin
      r_mem[i_imem_write_addr] <= i_imem_write_data;
    end
  end

  // Priority decode. Branch overrides stall (it flushes the stalled slot);
  // stall overrides the ID-stage redirects so a jr never uses a stale register.
  always_comb begin
    w_sel = SEL_HOLD;
    if (!i_pipeline_enable || r_halted) begin
      w_sel = SEL_HOLD;
    end else if (i_branch_taken) begin
      w_sel = SEL_BRANCH;
    end else if (i_stall) begin
      w_sel = SEL_HOLD;
    end else if (i_halt) begin
      w_sel = SEL_HALT;
    end else if (i_jr_jalr) begin
      w_sel = SEL_JR;
    end else if (i_jump) begin
      w_sel = SEL_JUMP;
    end else begin
      w_sel = SEL_SEQ;
    end
  end

  // Next-state values for PC, IF/ID and the halt flag; hold is the default.
  always_comb begin
    w_pc_next       = r_pc;
    w_inst_next     = r_inst;
    w_pc_plus1_next = r_pc_plus1;
    w_halted_next   = r_halted;
    case (w_sel)
      SEL_BRANCH: begin
        w_pc_next       = i_branch_addr;
        w_inst_next     = c_NOP;
        w_pc_plus1_next = '0;
      end
      SEL_HALT: begin
        w_halted_next   = 1'b1;
        w_inst_next     = c_NOP;
        w_pc_plus1_next = '0;
      end
      SEL_JR: begin
        w_pc_next       = i_jr_addr;
        w_inst_next     = c_NOP;
        w_pc_plus1_next = '0;
      end
      SEL_JUMP: begin
        w_pc_next       = i_jump_addr;
        w_inst_next     = c_NOP;
        w_pc_plus1_next = '0;
      end
      SEL_SEQ: begin
        w_pc_next       = w_pc_inc;
        w_inst_next     = w_fetch_word;
        w_pc_plus1_next = w_pc_inc;
      end
      default: begin
        w_pc_next       = r_pc;
        w_inst_next     = r_inst;
        w_pc_plus1_next = r_pc_plus1;
        w_halted_next   = r_halted;
      end
    endcase
  end

  // PC, IF/ID register and sticky halt flag; only reset clears the halt.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pc       <= '0;
      r_inst     <= c_NOP;
      r_pc_plus1 <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_inst     <= w_inst_next;
      r_pc_plus1 <= w_pc_plus1_next;
      r_halted   <= w_halted_next;
    end
  end

  assign o_inst       = r_inst;
  assign o_pc         = r_pc_plus1;
  assign o_pc_current = r_pc;
  assign o_halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Scoreboard bench for instruction_fetch. A driver applies
//             directed and random stimulus, a reference model predicts each
//             edge and queues the expectation, a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int c_DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, we, stall, br, jr, jmp, halt;
  logic [7:0]  waddr;
  logic [31:0] wdata, baddr, jraddr, jaddr;
  logic [31:0] d_inst, d_pc, d_pcur;
  logic        d_halted;

  always #5 clk = ~clk;

  instruction_fetch #(
    .INST_SIZE(32),
    .PC_SIZE(32),
    .IMEM_ADDR_SIZE(8)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_pipeline_enable(en),
    .i_imem_write_en(we),
    .i_imem_write_addr(waddr),
    .i_imem_write_data(wdata),
    .i_stall(stall),
    .i_branch_taken(br),
    .i_branch_addr(baddr),
    .i_jr_jalr(jr),
    .i_jr_addr(jraddr),
    .i_jump(jmp),
    .i_jump_addr(jaddr),
    .i_halt(halt),
    .o_inst(d_inst),
    .o_pc(d_pc),
    .o_pc_current(d_pcur),
    .o_halted(d_halted)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] opc;
    logic [31:0] pcur;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [31:0] m_mem [c_DEPTH];
  logic [31:0] m_pc, m_inst, m_opc;
  logic        m_halted;
  logic [31:0] t1_words [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 0; m_inst = 0; m_opc = 0; m_halted = 0;
  endtask

  // One clock edge of the block, described from the priority rules.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (en && !m_halted) begin
      if (br) begin
        m_pc = baddr; m_inst = 0; m_opc = 0;
      end else if (stall) begin
        // everything holds
      end else if (halt) begin
        m_halted = 1; m_inst = 0; m_opc = 0;
      end else if (jr) begin
        m_pc = jraddr; m_inst = 0; m_opc = 0;
      end else if (jmp) begin
        m_pc = jaddr; m_inst = 0; m_opc = 0;
      end else begin
        m_inst = m_mem[m_pc % c_DEPTH];
        m_opc  = m_pc + 1;
        m_pc   = m_pc + 1;
      end
    end
    if (we) m_mem[waddr] = wdata;
  endtask

  task automatic idle();
    en = 1; we = 0; waddr = 0; wdata = 0; stall = 0; br = 0; baddr = 0;
    jr = 0; jraddr = 0; jmp = 0; jaddr = 0; halt = 0;
  endtask

  // Predict, enqueue, and advance to the next falling edge.
  task automatic tick();
    model_step();
    exp_q.push_back({m_inst, m_opc, m_pc, m_halted});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic reset_async();
    #1 rst = 1;
    #1;
    check("async_rst_inst", d_inst, 32'h0);
    check("async_rst_pc", d_pc, 32'h0);
    check("async_rst_pcur", d_pcur, 32'h0);
    check("async_rst_halted", {31'b0, d_halted}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // Monitor: every edge with a pending expectation is compared.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mon_inst", d_inst, e.inst);
      check("mon_pc", d_pc, e.opc);
      check("mon_pc_current", d_pcur, e.pcur);
      check("mon_halted", {31'b0, d_halted}, {31'b0, e.halted});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_word, new_word;
    t1_words[0] = 32'hA0A0_0001; t1_words[1] = 32'hB0B0_0002;
    t1_words[2] = 32'hC0C0_0003; t1_words[3] = 32'hD0D0_0004;
    rst = 1;
    idle();
    en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_inst", d_inst, 32'h0);
    check("reset_pc", d_pc, 32'h0);
    check("reset_pcur", d_pcur, 32'h0);
    check("reset_halted", {31'b0, d_halted}, 32'h0);
    rst = 0;

    // Load the whole memory through the Debug Unit port with the pipeline frozen.
    en = 0;
    for (int i = 0; i < c_DEPTH; i++) begin
      we = 1; waddr = i[7:0];
      wdata = (i < 4) ? t1_words[i] : $urandom;
      tick();
    end
    idle();

    // T1: sequential fetch of A,B,C,D
    reset_async();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_inst", d_inst, t1_words[i]);
      check("t1_pc", d_pc, i + 1);
    end

    // T2: jump at pc=2
    reset_async();
    tick(); tick();
    jmp = 1; jaddr = 10;
    tick();
    jmp = 0;
    check("t2_flush_inst", d_inst, 32'h0);
    check("t2_flush_pc", d_pc, 32'h0);
    tick();
    check("t2_target_inst", d_inst, m_mem[10]);
    check("t2_target_pc", d_pc, 32'd11);

    // T3: branch beats stall, then stall alone freezes
    stall = 1; br = 1; baddr = 20;
    tick();
    br = 0;
    check("t3_branch_inst", d_inst, 32'h0);
    check("t3_branch_pcur", d_pcur, 32'd20);
    tick(); tick();
    stall = 0;
    check("t3_stall_pcur", d_pcur, 32'd20);
    check("t3_stall_inst", d_inst, 32'h0);

    // T4: halt at pc=5 ignores jumps until reset
    reset_async();
    repeat (5) tick();
    halt = 1;
    tick();
    halt = 0;
    check("t4_halted", {31'b0, d_halted}, 32'h1);
    jmp = 1; jaddr = 99;
    repeat (10) tick();
    jmp = 0;
    check("t4_hold_pcur", d_pcur, 32'd5);
    reset_async();

    // T5: enable low ignores jr; raising enable applies it
    tick();
    en = 0; jr = 1; jraddr = 7;
    tick();
    check("t5_frozen_pcur", d_pcur, 32'd1);
    en = 1;
    tick();
    jr = 0;
    check("t5_jr_pcur", d_pcur, 32'd7);
    repeat (3) tick();
    reset_async();

    // T6: wrap of the memory index, and read-before-write on same address
    jmp = 1; jaddr = 255;
    tick();
    jmp = 0;
    tick();
    check("t6_fetch_255", d_inst, m_mem[255]);
    check("t6_pcur_256", d_pcur, 32'd256);
    tick();
    check("t6_fetch_wrap", d_inst, m_mem[0]);
    check("t6_pc_257", d_pc, 32'd257);
    old_word = m_mem[1];
    new_word = ~old_word;
    we = 1; waddr = 8'd1; wdata = new_word;
    tick();
    we = 0;
    check("t6_old_word", d_inst, old_word);
    jmp = 1; jaddr = 1;
    tick();
    jmp = 0;
    tick();
    check("t6_new_word", d_inst, new_word);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      en     = ($urandom % 8) != 0;
      stall  = ($urandom % 6) == 0;
      br     = ($urandom % 10) == 0;
      baddr  = $urandom;
      jr     = ($urandom % 12) == 0;
      jraddr = $urandom;
      jmp    = ($urandom % 10) == 0;
      jaddr  = $urandom;
      halt   = ($urandom % 40) == 0;
      we     = ($urandom % 8) == 0;
      waddr  = $urandom;
      wdata  = $urandom;
      tick();
      if (m_halted && ($urandom % 16) == 0) begin
        idle();
        reset_async();
      end
    end

    idle();
    repeat (2) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
